// File: rtl/phase_stepper.sv
// ============================================================================
// phase_stepper : phase accumulator producing sample index, strobe and wrap,
//                 with FTW retune deferred to a waveform-cycle boundary.
// Revision 1.0
// ============================================================================
`default_nettype none

module phase_stepper #(
  parameter int                ACC_W     = 24,
  parameter int                IDX_W     = 9,
  parameter int                DIV       = 1,
  parameter logic [ACC_W-1:0]  FTW_RESET = ACC_W'(32768)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [ACC_W-1:0] ftw_i,
  input  logic             ftw_valid_i,
  output logic             ftw_ready_o,
  output logic [IDX_W-1:0] sample_index_o,
  output logic             sample_strobe_o,
  output logic             cycle_wrap_o
);

  localparam int              CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t             state_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   div_cnt_q;
  logic [ACC_W-1:0]   ftw_active_q;
  logic [ACC_W-1:0]   ftw_pend_q;
  logic [IDX_W-1:0]   sample_index_q;
  logic               sample_strobe_q;
  logic               cycle_wrap_q;

  logic [ACC_W:0]     acc_d;
  logic               tick;
  logic               running;
  logic               handshake;

  assign acc_d       = {1'b0, acc_q} + {1'b0, ftw_active_q};
  assign tick        = (state_q != IDLE) && (div_cnt_q == CNT_MAX);
  assign running     = (state_q != IDLE) && en_i;
  assign ftw_ready_o = (state_q != PEND);
  assign handshake   = ftw_valid_i && ftw_ready_o;

  assign sample_index_o  = sample_index_q;
  assign sample_strobe_o = sample_strobe_q;
  assign cycle_wrap_o    = cycle_wrap_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      acc_q           <= '0;
      div_cnt_q       <= '0;
      ftw_active_q    <= FTW_RESET;
      ftw_pend_q      <= '0;
      sample_index_q  <= '0;
      sample_strobe_q <= 1'b0;
      cycle_wrap_q    <= 1'b0;
    end else begin
      sample_strobe_q <= 1'b0;
      cycle_wrap_q    <= 1'b0;

      // Datapath: advance while enabled, otherwise park everything at zero.
      if (running) begin
        div_cnt_q <= tick ? '0 : div_cnt_q + 1'b1;
        if (tick) begin
          acc_q           <= acc_d[ACC_W-1:0];
          sample_index_q  <= acc_d[ACC_W-1 -: IDX_W];
          sample_strobe_q <= 1'b1;
          cycle_wrap_q    <= acc_d[ACC_W];
        end
      end else begin
        acc_q          <= '0;
        div_cnt_q      <= '0;
        sample_index_q <= '0;
      end

      unique case (state_q)
        IDLE: begin
          if (handshake) ftw_active_q <= ftw_i;
          if (en_i)      state_q      <= RUN;
        end
        RUN: begin
          if (!en_i) begin
            state_q <= IDLE;
            if (handshake) ftw_active_q <= ftw_i;
          end else if (handshake) begin
            ftw_pend_q <= ftw_i;
            state_q    <= PEND;
          end
        end
        PEND: begin
          // A zero FTW never carries, so it must not block the pending word.
          if (!en_i) begin
            state_q      <= IDLE;
            ftw_active_q <= ftw_pend_q;
          end else if (tick && (acc_d[ACC_W] || (ftw_active_q == '0))) begin
            state_q      <= RUN;
            ftw_active_q <= ftw_pend_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_phase_stepper.sv
// ============================================================================
// tb_phase_stepper : scoreboard bench; directed stimulus queues expected
//                    {wrap,index}, monitors pop and compare on each strobe.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_phase_stepper;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        en_a = 1'b0;
  logic [23:0] ftw_a = 24'd0;
  logic        valid_a = 1'b0;
  logic        ready_a;
  logic [8:0]  idx_a;
  logic        strobe_a;
  logic        wrap_a;

  logic        en_b = 1'b0;
  logic        ready_b;
  logic [8:0]  idx_b;
  logic        strobe_b;
  logic        wrap_b;

  logic [9:0]  qa[$];
  logic [9:0]  qb[$];
  int          checks = 0;
  int          passed = 0;
  int          cyc = 0;

  always #5 clk = ~clk;

  phase_stepper #(.ACC_W(24), .IDX_W(9), .DIV(1), .FTW_RESET(24'd32768)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .en_i(en_a), .ftw_i(ftw_a), .ftw_valid_i(valid_a),
    .ftw_ready_o(ready_a), .sample_index_o(idx_a), .sample_strobe_o(strobe_a),
    .cycle_wrap_o(wrap_a)
  );

  phase_stepper #(.ACC_W(24), .IDX_W(9), .DIV(4), .FTW_RESET(24'd32768)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .en_i(en_b), .ftw_i(24'd0), .ftw_valid_i(1'b0),
    .ftw_ready_o(ready_b), .sample_index_o(idx_b), .sample_strobe_o(strobe_b),
    .cycle_wrap_o(wrap_b)
  );

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic push_a(input int idx, input bit w);
    qa.push_back({w, idx[8:0]});
  endtask

  task automatic wait_idx_a(input int idx, input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(strobe_a && (idx_a == 9'(idx))) && (n < 3000));
    if (n >= 3000) check({nm, "_timeout"}, 1, 0);
  endtask

  always @(negedge clk) cyc++;

  // Monitor A: every strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (strobe_a) begin
        if (qa.size() == 0) check("unexpected_strobe_a", int'(idx_a), -1);
        else begin
          logic [9:0] e;
          e = qa.pop_front();
          check("idx_a", int'(idx_a), int'(e[8:0]));
          check("wrap_a", int'(wrap_a), int'(e[9]));
        end
      end else if (wrap_a) begin
        check("wrap_without_strobe_a", 1, 0);
      end
    end
  end

  // Monitor B: index/wrap from the queue, plus exact DIV spacing of strobes.
  int last_b = -1;
  always @(negedge clk) begin
    if (rst_n && strobe_b) begin
      if (qb.size() == 0) check("unexpected_strobe_b", int'(idx_b), -1);
      else begin
        logic [9:0] e;
        e = qb.pop_front();
        check("idx_b", int'(idx_b), int'(e[8:0]));
        check("wrap_b", int'(wrap_b), int'(e[9]));
      end
      if (last_b >= 0) check("gap_b", cyc - last_b, 4);
      last_b = cyc;
    end
  end

  initial begin
    int n;
    // Reset values
    @(negedge clk);
    @(negedge clk);
    check("rst_idx", int'(idx_a), 0);
    check("rst_strobe", int'(strobe_a), 0);
    check("rst_wrap", int'(wrap_a), 0);
    check("rst_ready", int'(ready_a), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // DIV=4 instance: one strobe every 4 clocks, index +1 per strobe
    for (int i = 1; i <= 6; i++) qb.push_back({1'b0, 9'(i)});
    en_b = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(strobe_b && idx_b == 9'd6) && n < 200);
    if (n >= 200) check("b_timeout", 1, 0);
    en_b = 1'b0;
    @(negedge clk);

    // Full default sweep, then on into the second cycle up to index 100
    for (int i = 1; i <= 511; i++) push_a(i, 1'b0);
    push_a(0, 1'b1);
    for (int i = 1; i <= 100; i++) push_a(i, 1'b0);
    en_a = 1'b1;
    wait_idx_a(0, "first_wrap");
    wait_idx_a(100, "idx100");

    // Retune at index 100 to 2^16: applies only after the wrap
    ftw_a = 24'd65536;
    valid_a = 1'b1;
    for (int i = 101; i <= 511; i++) push_a(i, 1'b0);
    push_a(0, 1'b1);
    for (int i = 2; i <= 10; i += 2) push_a(i, 1'b0);
    @(negedge clk);
    valid_a = 1'b0;
    check("ready_drop", int'(ready_a), 0);
    wait_idx_a(511, "idx511");
    check("ready_before_wrap", int'(ready_a), 0);
    wait_idx_a(0, "retune_wrap");
    check("ready_after_wrap", int'(ready_a), 1);
    wait_idx_a(10, "idx10");

    // Disable from RUN: cleared, no strobe
    en_a = 1'b0;
    @(negedge clk);
    check("idle_idx", int'(idx_a), 0);
    check("idle_strobe", int'(strobe_a), 0);
    check("idle_ready", int'(ready_a), 1);

    // Zero FTW loaded in IDLE, then 2^15 written while running
    ftw_a = 24'd0;
    valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    en_a = 1'b1;
    push_a(0, 1'b0);
    push_a(0, 1'b0);
    for (int i = 1; i <= 300; i++) push_a(i, 1'b0);
    @(negedge clk);
    ftw_a = 24'd32768;
    valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    wait_idx_a(299, "idx299");

    // Enter PEND at index 300, then drop en while pending
    ftw_a = 24'd65536;
    valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    check("pend_ready", int'(ready_a), 0);
    check("pend_idx", int'(idx_a), 300);
    en_a = 1'b0;
    @(negedge clk);
    check("pend_drop_idx", int'(idx_a), 0);
    check("pend_drop_strobe", int'(strobe_a), 0);
    check("pend_drop_ready", int'(ready_a), 1);

    // Re-enable: pending word (2^16) was applied on the drop
    push_a(2, 1'b0);
    push_a(4, 1'b0);
    push_a(6, 1'b0);
    en_a = 1'b1;
    wait_idx_a(6, "reenable_idx6");

    // Asynchronous reset pulse between clock edges
    #1 rst_n = 1'b0;
    #1;
    check("async_idx", int'(idx_a), 0);
    check("async_strobe", int'(strobe_a), 0);
    check("async_wrap", int'(wrap_a), 0);
    check("async_ready", int'(ready_a), 1);
    push_a(1, 1'b0);
    push_a(2, 1'b0);
    push_a(3, 1'b0);
    #1 rst_n = 1'b1;
    wait_idx_a(3, "post_reset_idx3");
    en_a = 1'b0;
    repeat (10) @(negedge clk);

    check("qa_empty", qa.size(), 0);
    check("qb_empty", qb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
